// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave register file: parametrised width/depth, per-register read-only mask,
// SLVERR on out-of-range or read-only writes, independent AW/W capture.
module axi4lite_slave_regfile #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam int         ADDR_LSB    = $clog2(STRB_W);
  localparam int         IDX_W       = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  ready_en_q;
  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      ar_idx;
  logic                  wr_in_range, wr_ro, wr_ok;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_addr_lsbs;

  assign AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
  assign WREADY  = ready_en_q && !w_held_q && !bvalid_q;
  assign ARREADY = ready_en_q && !rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = aw_held_q && w_held_q;
  assign ar_idx = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  // Sub-word address bits carry no meaning for a word-wide register file.
  assign unused_addr_lsbs = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  always_comb begin
    wr_in_range = 1'b0;
    wr_ro       = 1'b0;
    rd_in_range = 1'b0;
    rd_data     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(aw_idx_q) == i) begin
        wr_in_range = 1'b1;
        wr_ro       = RO_MASK[i];
      end
      if (int'(ar_idx) == i) begin
        rd_in_range = 1'b1;
        rd_data     = regs_q[i];
      end
    end
    wr_ok = wr_in_range && !wr_ro;
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    // Readies are low while both holds are set, so a commit never overlaps a new capture.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && int'(aw_idx_q) == i) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
          end
        end
      end
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? rd_data : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      regs_q     <= '{default: '0};
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
    end
  end

endmodule
